// File: rtl/multicycle_mem.sv
// rtl/multicycle_mem.sv - fully pipelined 16-bit word memory with fixed read latency
module multicycle_mem #(
    parameter int LATENCY        = 4,
    parameter int WORD_ADDR_BITS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [2:0]  pending
);

    localparam int DEPTH = 1 << WORD_ADDR_BITS;

    // Storage is never reset; unwritten words read back as X in simulation.
    logic [15:0]               mem_q [DEPTH];
    logic [WORD_ADDR_BITS-1:0] word_idx;
    logic                      wr_en;
    logic                      rd_en;

    // Response pipeline: valid bits are reset, data rides along ungated.
    logic [LATENCY-1:0]        vld_q;
    logic [15:0]               dat_q [LATENCY];

    logic [2:0]                pending_q;
    logic [2:0]                pending_d;

    // addr[0] and bits above the word index only alias; fold them away.
    logic                      unused_addr;
    assign unused_addr = ^addr;

    assign word_idx = addr[WORD_ADDR_BITS:1];

    // A request presented while rst is high is dropped entirely.
    assign wr_en = enable &  wr & ~rst;
    assign rd_en = enable & ~wr & ~rst;

    // Write port: commits at the edge ending the request cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= data_in;
        end
    end

    // Valid shift chain; reset drops every read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_en;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data shift chain; stage 0 samples the array before this edge's write,
    // which is safe because a read and a write never share a cycle.
    always_ff @(posedge clk) begin
        dat_q[0] <= mem_q[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    // Outstanding-read count: accept and return in one cycle cancel out.
    always_comb begin
        pending_d = pending_q;
        if (rd_en && !data_valid) begin
            pending_d = pending_q + 3'd1;
        end else if (!rd_en && data_valid) begin
            pending_d = pending_q - 3'd1;
        end
    end

    // Pending counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 3'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign data_valid = vld_q[LATENCY-1];
    assign data_out   = data_valid ? dat_q[LATENCY-1] : 16'h0000;
    assign pending    = pending_q;

endmodule

// File: tb/tb_multicycle_mem.sv
// tb/tb_multicycle_mem.sv - scoreboard bench for multicycle_mem at latencies 4, 1 and 7
module tb_multicycle_mem;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{4, 1, 7};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic [15:0] dout [NDUT];
    logic        dv   [NDUT];
    logic [2:0]  pend [NDUT];

    exp_t        sbq [NDUT][$];
    logic [15:0] model_mem [int];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    multicycle_mem #(.LATENCY(4), .WORD_ADDR_BITS(15)) u_dut_l4 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout[0]), .data_valid(dv[0]), .pending(pend[0])
    );

    multicycle_mem #(.LATENCY(1), .WORD_ADDR_BITS(15)) u_dut_l1 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout[1]), .data_valid(dv[1]), .pending(pend[1])
    );

    multicycle_mem #(.LATENCY(7), .WORD_ADDR_BITS(15)) u_dut_l7 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout[2]), .data_valid(dv[2]), .pending(pend[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Compare this cycle's outputs, then present the next request and update the model.
    task automatic step(input logic r, input logic en, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("pending_L%0d", LAT[k]), {29'b0, pend[k]}, sbq[k].size());
                if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
                    chk($sformatf("data_valid_L%0d", LAT[k]), {31'b0, dv[k]}, 32'd1);
                    chk($sformatf("data_out_L%0d", LAT[k]), {16'b0, dout[k]}, {16'b0, sbq[k][0].data});
                    void'(sbq[k].pop_front());
                end else begin
                    chk($sformatf("idle_valid_L%0d", LAT[k]), {31'b0, dv[k]}, 32'd0);
                    chk($sformatf("idle_data_L%0d", LAT[k]), {16'b0, dout[k]}, 32'd0);
                end
            end
        end
        rst     = r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        if (r) begin
            for (int k = 0; k < NDUT; k++) sbq[k].delete();
        end else if (en) begin
            if (w) begin
                model_mem[int'(a[15:1])] = d;
            end else begin
                for (int k = 0; k < NDUT; k++) begin
                    e.data = model_mem[int'(a[15:1])];
                    e.due  = cyc + LAT[k];
                    sbq[k].push_back(e);
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wr_op(input logic [15:0] a, input logic [15:0] d);
        step(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd_op(input logic [15:0] a);
        step(1'b0, 1'b1, 1'b0, a, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk_en = 1'b1;
        idle(2);

        // Basic read
        wr_op(16'h0010, 16'hBEEF);
        idle(1);
        rd_op(16'h0010);
        idle(9);

        // Streaming fill
        wr_op(16'h0100, 16'd1);
        wr_op(16'h0102, 16'd2);
        wr_op(16'h0104, 16'd3);
        wr_op(16'h0106, 16'd4);
        rd_op(16'h0100);
        rd_op(16'h0102);
        rd_op(16'h0104);
        rd_op(16'h0106);
        idle(9);

        // Read-after-write and write-after-read hazards
        wr_op(16'h0020, 16'h1111);
        rd_op(16'h0020);
        rd_op(16'h0020);
        wr_op(16'h0020, 16'h2222);
        rd_op(16'h0020);
        idle(9);

        // Odd address aliasing and a mixed R, W, R stream
        wr_op(16'h0031, 16'hA5A5);
        rd_op(16'h0030);
        wr_op(16'h0040, 16'h1234);
        rd_op(16'h0031);
        idle(9);

        // Reset mid-flight, with a read and then a write presented under reset
        rd_op(16'h0010);
        rd_op(16'h0020);
        rd_op(16'h0030);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
        idle(10);
        rd_op(16'h0040);
        idle(9);

        // Random mixed traffic over a preloaded window
        for (int i = 0; i < 16; i++) wr_op(16'h0200 + 16'(i * 2), 16'($urandom));
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            a = 16'h0200 + 16'($urandom_range(0, 15) * 2) + 16'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       idle(1);
                1:       wr_op(a, 16'($urandom));
                default: rd_op(a);
            endcase
        end
        idle(10);

        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("drained_L%0d", LAT[k]), sbq[k].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
